// File: rtl/weight_loader_r_pkg.sv
// weight_load_pkg: shared types and defaults for the weight loader.
// Optional feature macro: WEIGHT_LOAD_CKSUM_EN (adds the trailing checksum beat).
package weight_load_pkg;

  localparam int unsigned M_DEF       = 8;
  localparam int unsigned TAPS_DEF    = 18;
  localparam int unsigned FILTERS_DEF = 8;
  localparam int unsigned WORD_W_DEF  = M_DEF * TAPS_DEF;

  // Packed filter word width for a given tap width and tap count.
  function automatic int unsigned word_width(input int unsigned m, input int unsigned taps);
    return m * taps;
  endfunction

`ifdef WEIGHT_LOAD_CKSUM_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CKSUM   = 3'd3,
    DONE    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/weight_loader_r_packer.sv
// weight_word_packer: shifts taps into one filter word, first tap ends in the top slice.
// Behaviour is identical with or without WEIGHT_LOAD_CKSUM_EN.
module weight_word_packer
  import weight_load_pkg::*;
#(
  parameter int unsigned M    = M_DEF,
  parameter int unsigned TAPS = TAPS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic [M-1:0]      data,
  output logic [M*TAPS-1:0] word,
  output logic              word_full
);

  localparam int unsigned TW = $clog2(TAPS);
  localparam logic [TW-1:0] TAP_LAST = TW'(TAPS - 1);

  logic [TW-1:0] tap_cnt;

  // The current beat completes the word.
  assign word_full = shift && (tap_cnt == TAP_LAST);

  // Shift register and tap counter; the counter wraps on the completing beat,
  // so it already reads zero when the FSM returns to collecting.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word    <= '0;
      tap_cnt <= '0;
    end else if (shift) begin
      word    <= {word[M*(TAPS-1)-1:0], data};
      tap_cnt <= word_full ? '0 : tap_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/weight_loader_r.sv
// weight_loader_r: packs a tap byte stream into FILTERS words and writes them
// to weight memory addresses 0..FILTERS-1, with framing checks.
// Optional feature macro: WEIGHT_LOAD_CKSUM_EN (trailing checksum beat checked against tap sum).
module weight_loader_r
  import weight_load_pkg::*;
#(
  parameter int unsigned M       = M_DEF,
  parameter int unsigned TAPS    = TAPS_DEF,
  parameter int unsigned FILTERS = FILTERS_DEF,
  parameter int unsigned AW      = 8
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              load_start,
  input  logic              s_valid,
  input  logic [M-1:0]      s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [M*TAPS-1:0] wr_data,
  output logic              busy,
  output logic              load_done,
  output logic              err
);

  localparam int unsigned WW = word_width(M, TAPS);
  localparam logic [AW-1:0] FILT_LAST = AW'(FILTERS - 1);

  state_t          state, state_nx;
  logic [AW-1:0]   filt_cnt;
  logic [WW-1:0]   word;
  logic            word_full;
  logic            tap_beat;
  logic            last_filt;
  logic            final_tap;
  logic            clr;
  logic            filt_inc;
  logic            err_set;

  assign tap_beat  = (state == COLLECT) && s_valid;
  assign last_filt = (filt_cnt == FILT_LAST);
  assign busy      = (state != IDLE);

`ifdef WEIGHT_LOAD_CKSUM_EN
  // With the checksum beat enabled no tap is ever the final beat of a load.
  assign final_tap = 1'b0;
`else
  assign final_tap = word_full && last_filt;
`endif

  weight_word_packer #(
    .M    (M),
    .TAPS (TAPS)
  ) u_packer (
    .clk       (clk),
    .rst       (Rst),
    .clear     (clr),
    .shift     (tap_beat),
    .data      (s_data),
    .word      (word),
    .word_full (word_full)
  );

`ifdef WEIGHT_LOAD_CKSUM_EN
  logic [M-1:0] sum;

  // Wrapping sum of every tap accepted during the current load.
  always_ff @(posedge clk) begin
    if (Rst || clr) begin
      sum <= '0;
    end else if (tap_beat) begin
      sum <= sum + s_data;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Filter address counter, cleared on every accepted load request.
  always_ff @(posedge clk) begin
    if (Rst || clr) begin
      filt_cnt <= '0;
    end else if (filt_inc) begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Sticky error flag, cleared only by the next accepted load request.
  always_ff @(posedge clk) begin
    if (Rst || clr) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

  // Next-state, handshake, memory write port and framing decisions.
  always_comb begin
    state_nx  = state;
    s_ready   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    load_done = 1'b0;
    clr       = 1'b0;
    filt_inc  = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          clr      = 1'b1;
          state_nx = COLLECT;
        end
      end
      COLLECT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_last && !final_tap) begin
            err_set  = 1'b1;
            state_nx = IDLE;
          end else begin
            if (final_tap && !s_last) begin
              err_set = 1'b1;
            end
            if (word_full) begin
              state_nx = WRITE;
            end
          end
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        wr_addr = filt_cnt;
        wr_data = word;
        if (last_filt) begin
`ifdef WEIGHT_LOAD_CKSUM_EN
          state_nx = CKSUM;
`else
          state_nx = DONE;
`endif
        end else begin
          filt_inc = 1'b1;
          state_nx = COLLECT;
        end
      end
`ifdef WEIGHT_LOAD_CKSUM_EN
      CKSUM: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if ((s_data != sum) || !s_last) begin
            err_set = 1'b1;
          end
          state_nx = DONE;
        end
      end
`endif
      DONE: begin
        load_done = 1'b1;
        state_nx  = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
